// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu: load/store unit between EXU and the data-memory stage.
// One op in flight at a time: IDLE accepts, ACCESS holds the memory port for
// MEM_LAT cycles, RESP presents the formatted result to WBU.
// Optional build macro YSYX_23060332_LSU_MISALIGN_CHECK_EN: misaligned
// halfword/word ops skip the memory access and return out_err=1.
module ysyx_23060332_lsu #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_load,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_ren,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_load, r_is_store, r_err;
    logic [2:0]        r_funct3;
    logic [31:0]       r_addr, r_wdata, r_rdata;
    logic [7:0]        r_wmask;
    logic [4:0]        r_rd;

    logic              w_mem_op, w_misalign, w_accept;
    logic [1:0]        w_sh;
    logic [7:0]        w_st_mask;
    logic [31:0]       w_st_data, w_ld_data;

    assign w_mem_op = in_is_load | in_is_store;
    assign w_sh     = in_addr[1:0];
    assign w_accept = (r_state == IDLE) && in_valid;

`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    assign w_misalign = ((in_funct3[1:0] == 2'b01) && in_addr[0]) ||
                        (in_funct3[1] && (in_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane placement; lanes pushed past byte 3 are dropped
    always_comb begin
        w_st_mask = 8'h0F;
        w_st_data = in_wdata;
        case (in_funct3[1:0])
            2'b00: begin
                w_st_mask = 8'h01 << w_sh;
                w_st_data = {24'b0, in_wdata[7:0]} << {w_sh, 3'b000};
            end
            2'b01: begin
                w_st_mask = 8'h03 << w_sh;
                w_st_data = {16'b0, in_wdata[15:0]} << {w_sh, 3'b000};
            end
            default: ;
        endcase
        w_st_mask = w_st_mask & 8'h0F;
    end

    // Load extension from the already byte-aligned read data
    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b100:  w_ld_data = {24'b0, mem_rdata[7:0]};
            3'b001:  w_ld_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b101:  w_ld_data = {16'b0, mem_rdata[15:0]};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state and handshake / memory strobes
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = (w_mem_op && !w_misalign) ? ACCESS : RESP;
            end
            ACCESS: begin
                mem_ren = r_is_load;
                // counter still at its load value only on the first cycle
                mem_wen = r_is_store && (r_cnt == LAT_M1);
                if (r_cnt == '0) w_next = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Op capture, latency counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
            r_funct3   <= 3'b0;
            r_addr     <= 32'b0;
            r_wdata    <= 32'b0;
            r_wmask    <= 8'b0;
            r_rd       <= 5'b0;
            r_rdata    <= 32'b0;
        end else if (w_accept) begin
            r_cnt      <= LAT_M1;
            r_is_load  <= in_is_load;
            r_is_store <= in_is_store & ~in_is_load;
            r_err      <= w_mem_op & w_misalign;
            r_funct3   <= in_funct3;
            r_addr     <= in_addr;
            r_wdata    <= w_st_data;
            r_wmask    <= w_st_mask;
            r_rd       <= in_rd;
            r_rdata    <= 32'b0;
        end else if (r_state == ACCESS) begin
            if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            else             r_rdata <= r_is_load ? w_ld_data : 32'b0;
        end
    end

    assign mem_raddr = r_addr;
    assign mem_waddr = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign out_rdata = r_rdata;
    assign out_rd    = r_rd;
    assign out_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Bench for ysyx_23060332_lsu: three instances (MEM_LAT 1, 3, 4) share clock
// and reset; a transaction-level model predicts every output each cycle.
module tb_ysyx_23060332_lsu;

    localparam int N = 3;
    localparam int LATS [N] = '{1, 3, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid [N], in_ready [N], in_is_load [N], in_is_store [N];
    logic [2:0]  in_funct3 [N];
    logic [31:0] in_addr [N], in_wdata [N];
    logic [4:0]  in_rd [N];
    logic        mem_ren [N], mem_wen [N];
    logic [31:0] mem_raddr [N], mem_rdata [N], mem_waddr [N], mem_wdata [N];
    logic [7:0]  mem_wmask [N];
    logic        out_valid [N], out_ready [N], out_err [N];
    logic [31:0] out_rdata [N];
    logic [4:0]  out_rd [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        ysyx_23060332_lsu #(.MEM_LAT(LATS[g]), .CNT_W(4)) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_is_load(in_is_load[g]), .in_is_store(in_is_store[g]),
            .in_funct3(in_funct3[g]), .in_addr(in_addr[g]),
            .in_wdata(in_wdata[g]), .in_rd(in_rd[g]),
            .mem_ren(mem_ren[g]), .mem_raddr(mem_raddr[g]), .mem_rdata(mem_rdata[g]),
            .mem_wen(mem_wen[g]), .mem_waddr(mem_waddr[g]), .mem_wdata(mem_wdata[g]),
            .mem_wmask(mem_wmask[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_rdata(out_rdata[g]), .out_rd(out_rd[g]), .out_err(out_err[g])
        );
    end

    int checks = 0;
    int failures = 0;

    // ---------------- model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        int n = nbytes(f3);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return (f3 == 3'b111) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return 32'($signed(d[7:0]));
            3'b100:  return 32'(d[7:0]);
            3'b001:  return 32'($signed(d[15:0]));
            3'b101:  return 32'(d[15:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic [7:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        longint m;
        if (n == 4) return 8'h0F;
        m = ((64'd1 << n) - 1) << a[1:0];
        return 8'(m & 15);
    endfunction

    function automatic logic [31:0] exp_data(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] wd);
        int n = nbytes(f3);
        longint d;
        if (n == 4) return wd;
        d = (longint'(wd) & ((64'd1 << (8 * n)) - 1)) << (8 * a[1:0]);
        return d[31:0];
    endfunction

    logic        m_busy [N], m_load [N], m_store [N], m_err [N];
    int          m_age [N], m_lat [N];
    logic [2:0]  m_f3 [N];
    logic [31:0] m_addr [N], m_wd [N], m_res [N];
    logic [4:0]  m_rd [N];

    // Each op: accept edge, then m_lat edges of memory access, then wait for out_ready
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_busy[i] <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) begin
                    if (in_valid[i]) begin
                        m_busy[i]  <= 1'b1;
                        m_age[i]   <= 0;
                        m_load[i]  <= in_is_load[i];
                        m_store[i] <= in_is_store[i] && !in_is_load[i];
                        m_f3[i]    <= in_funct3[i];
                        m_addr[i]  <= in_addr[i];
                        m_wd[i]    <= in_wdata[i];
                        m_rd[i]    <= in_rd[i];
                        m_res[i]   <= 32'h0;
                        m_err[i]   <= (in_is_load[i] || in_is_store[i]) && mis(in_funct3[i], in_addr[i]);
                        m_lat[i]   <= ((in_is_load[i] || in_is_store[i]) && !mis(in_funct3[i], in_addr[i]))
                                      ? LATS[i] : 0;
                    end
                end else if (m_age[i] >= m_lat[i]) begin
                    if (out_ready[i]) m_busy[i] <= 1'b0;
                end else begin
                    if (m_age[i] == m_lat[i] - 1 && m_load[i]) m_res[i] <= fmt(m_f3[i], mem_rdata[i]);
                    m_age[i] <= m_age[i] + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic cmp_all();
        logic e_ren, e_wen, e_ov;
        if (rst) return;
        for (int i = 0; i < N; i++) begin
            e_ov  = m_busy[i] && (m_age[i] >= m_lat[i]);
            e_ren = m_busy[i] && m_load[i] && (m_age[i] < m_lat[i]);
            e_wen = m_busy[i] && m_store[i] && (m_age[i] == 0) && (m_lat[i] > 0);
            chk("in_ready", i, 32'(in_ready[i]), 32'(!m_busy[i]));
            chk("mem_ren", i, 32'(mem_ren[i]), 32'(e_ren));
            chk("mem_wen", i, 32'(mem_wen[i]), 32'(e_wen));
            chk("out_valid", i, 32'(out_valid[i]), 32'(e_ov));
            if (e_ren) chk("mem_raddr", i, mem_raddr[i], m_addr[i]);
            if (e_wen) begin
                chk("mem_waddr", i, mem_waddr[i], {m_addr[i][31:2], 2'b00});
                chk("mem_wmask", i, 32'(mem_wmask[i]), 32'(exp_mask(m_f3[i], m_addr[i])));
                chk("mem_wdata", i, mem_wdata[i], exp_data(m_f3[i], m_addr[i], m_wd[i]));
            end
            if (e_ov) begin
                chk("out_rdata", i, out_rdata[i], m_res[i]);
                chk("out_rd", i, 32'(out_rd[i]), 32'(m_rd[i]));
                chk("out_err", i, 32'(out_err[i]), 32'(m_err[i]));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        cmp_all();
    endtask

    // Present one op for a single edge; returns at the negedge after acceptance
    task automatic issue(input int i, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        in_valid[i] = 1'b1; in_is_load[i] = ld; in_is_store[i] = st;
        in_funct3[i] = f3; in_addr[i] = a; in_wdata[i] = wd; in_rd[i] = rd;
        step();
        in_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(input int i);
        for (int k = 0; k < 32 && out_valid[i] !== 1'b1; k++) step();
        chk("resp_seen", i, 32'(out_valid[i]), 32'd1);
    endtask

    initial begin
        int ren_n, steps;
        for (int i = 0; i < N; i++) begin
            in_valid[i] = 1'b0; in_is_load[i] = 1'b0; in_is_store[i] = 1'b0;
            in_funct3[i] = 3'b0; in_addr[i] = 32'h0; in_wdata[i] = 32'h0; in_rd[i] = 5'h0;
            mem_rdata[i] = 32'h0; out_ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_in_ready", i, 32'(in_ready[i]), 32'd1);
            chk("rst_ren_wen", i, {mem_ren[i], mem_wen[i], out_valid[i], out_err[i]}, 32'd0);
            chk("rst_addr", i, mem_raddr[i] | mem_waddr[i] | mem_wdata[i] | out_rdata[i], 32'd0);
            chk("rst_wmask", i, 32'(mem_wmask[i]), 32'd0);
        end
        rst = 1'b0;
        step();

        // SB lane shift on the MEM_LAT=1 instance
        issue(0, 1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 5'd3);
        chk("sb_wen", 0, 32'(mem_wen[0]), 32'd1);
        chk("sb_waddr", 0, mem_waddr[0], 32'h8000_0000);
        chk("sb_wmask", 0, 32'(mem_wmask[0]), 32'h08);
        chk("sb_wdata", 0, mem_wdata[0], 32'hAB00_0000);
        step();
        chk("sb_rdata", 0, out_rdata[0], 32'h0);
        step();

        // Sign vs zero extension
        mem_rdata[0] = 32'h0000_00F0;
        issue(0, 1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0, 5'd4);
        wait_resp(0); chk("lb", 0, out_rdata[0], 32'hFFFF_FFF0); step();
        issue(0, 1'b1, 1'b0, 3'b100, 32'h8000_0001, 32'h0, 5'd5);
        wait_resp(0); chk("lbu", 0, out_rdata[0], 32'h0000_00F0); step();
        mem_rdata[0] = 32'h0000_8001;
        issue(0, 1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 5'd6);
        wait_resp(0); chk("lh", 0, out_rdata[0], 32'hFFFF_8001); step();
        issue(0, 1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0, 5'd6);
        wait_resp(0); chk("lhu", 0, out_rdata[0], 32'h0000_8001); step();

        // SH and SW lanes
        issue(0, 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 5'd0);
        chk("sh_wmask", 0, 32'(mem_wmask[0]), 32'h0C);
        chk("sh_wdata", 0, mem_wdata[0], 32'hBEEF_0000);
        step(); step();
`ifndef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        issue(0, 1'b0, 1'b1, 3'b001, 32'h8000_0003, 32'h1234_BEEF, 5'd0);
        chk("sh3_wmask", 0, 32'(mem_wmask[0]), 32'h08);
        chk("sh3_wdata", 0, mem_wdata[0], 32'hEF00_0000);
        step(); step();
`endif
        issue(0, 1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 5'd0);
        chk("sw_wmask", 0, 32'(mem_wmask[0]), 32'h0F);
        step(); step();

        // Latency and stall on the MEM_LAT=4 instance
        mem_rdata[2] = 32'h1234_5678;
        out_ready[2] = 1'b0;
        issue(2, 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd2);
        ren_n = mem_ren[2] ? 1 : 0;
        steps = 0;
        while (out_valid[2] !== 1'b1 && steps < 32) begin
            step(); steps++;
            if (mem_ren[2]) ren_n++;
        end
        chk("lat_steps", 2, 32'(steps), 32'd4);
        chk("ren_cycles", 2, 32'(ren_n), 32'd4);
        in_valid[2] = 1'b1; in_is_load[2] = 1'b0; in_is_store[2] = 1'b0; in_rd[2] = 5'd9;
        repeat (3) begin
            step();
            chk("stall_rdata", 2, out_rdata[2], 32'h1234_5678);
            chk("stall_ready", 2, 32'(in_ready[2]), 32'd0);
        end
        out_ready[2] = 1'b1;
        step();
        chk("post_hs_valid", 2, 32'(out_valid[2]), 32'd0);
        step();
        chk("second_op_rd", 2, 32'(out_rd[2]), 32'd9);
        in_valid[2] = 1'b0;
        step();

        // Non-memory op
        issue(1, 1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 5'd7);
        chk("nm_valid", 1, 32'(out_valid[1]), 32'd1);
        chk("nm_rd", 1, 32'(out_rd[1]), 32'd7);
        chk("nm_rdata", 1, out_rdata[1], 32'h0);
        step();

        // Misaligned word load
        mem_rdata[1] = 32'hCAFE_BABE;
        issue(1, 1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 5'd8);
`ifdef YSYX_23060332_LSU_MISALIGN_CHECK_EN
        chk("mis_ren", 1, 32'(mem_ren[1]), 32'd0);
        chk("mis_err", 1, 32'(out_err[1]), 32'd1);
        chk("mis_rdata", 1, out_rdata[1], 32'h0);
`else
        chk("mis_ren", 1, 32'(mem_ren[1]), 32'd1);
        wait_resp(1);
        chk("mis_err", 1, 32'(out_err[1]), 32'd0);
        chk("mis_rdata", 1, out_rdata[1], 32'hCAFE_BABE);
`endif
        step();

        // Load and store together: load wins, no write
        issue(1, 1'b1, 1'b1, 3'b010, 32'h8000_0008, 32'h5555_5555, 5'd10);
        chk("ldst_ren", 1, 32'(mem_ren[1]), 32'd1);
        chk("ldst_wen", 1, 32'(mem_wen[1]), 32'd0);
        wait_resp(1); step();

        // Reset during store ACCESS on the MEM_LAT=3 instance
        issue(1, 1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'h1122_3344, 5'd11);
        chk("rs_wen_before", 1, 32'(mem_wen[1]), 32'd1);
        #1 rst = 1'b1;
        #1 chk("rs_wen_async", 1, 32'(mem_wen[1]), 32'd0);
        chk("rs_ren_async", 1, 32'(mem_ren[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step();
        chk("rs_ready", 1, 32'(in_ready[1]), 32'd1);
        chk("rs_valid", 1, 32'(out_valid[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_lsu.md
Name: ysyx_23060332_lsu

Overview:
- Load/store unit between EXU and the data-memory DPI stage.
- Accepts one memory op per handshake from EXU and drives the memory stage's read/write port.
  - Read port: mem_ren/mem_raddr/mem_rdata.
  - Write port: mem_wen/mem_waddr/mem_wdata/mem_wmask.
- Formats and sign-extends load data, then hands the result to WBU over a valid/ready handshake.
- A counter models a configurable SRAM access latency.

Parameters:
- MEM_LAT, 1: cycles in ACCESS per op; legal range 1..15.
- CNT_W, 4: width of the latency counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EXU op valid.
- in_ready  out  1  LSU can accept an op.
- in_is_load  in  1  op is a load.
- in_is_store  in  1  op is a store.
- in_funct3  in  3  RV32 funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- in_addr  in  32  effective address.
- in_wdata  in  32  store data, unshifted (rs2).
- in_rd  in  5  destination register.
- mem_ren  out  1  read enable.
- mem_raddr  out  32  read address, unaligned pass-through.
- mem_rdata  in  32  read data, already byte-aligned to mem_raddr by the memory stage.
- mem_wen  out  1  write enable.
- mem_waddr  out  32  write address, {addr[31:2],2'b00}.
- mem_wdata  out  32  lane-shifted store data.
- mem_wmask  out  8  byte-lane mask; bits [7:4] always 0.
- out_valid  out  1  result valid to WBU.
- out_ready  in  1  WBU accepts result.
- out_rdata  out  32  formatted load data; 0 for stores and non-memory ops.
- out_rd  out  5  destination register.
- out_err  out  1  misalignment flag; tied 0 unless the optional feature is compiled in.

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - State IDLE.
  - Outputs low: in_ready=1, mem_ren=0, mem_wen=0, out_valid=0, out_err=0.
  - All addr/data/mask outputs 0; counter 0.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: in_ready=1.
    - On in_valid with a load or store: latch op fields, counter := MEM_LAT-1, go to ACCESS.
    - On in_valid with in_is_load=in_is_store=0: latch rd, out_rdata := 0, go to RESP with no memory access.
  - ACCESS: in_ready=0.
    - Load: mem_ren=1 and mem_raddr=latched addr for every ACCESS cycle.
    - Store: mem_wen=1 on the first ACCESS cycle only, so exactly one write posedge per store.
    - Counter decrements each cycle. When the counter is 0: sample mem_rdata, format it into out_rdata, go to RESP.
  - RESP: out_valid=1; out_rdata, out_rd, out_err stable. On out_ready, go to IDLE. in_ready=0.
- Handshakes:
  - Transfer occurs when valid && ready at the rising edge.
  - At most one op in flight; in_valid during ACCESS/RESP is ignored and stalls upstream.
- Latency: an op accepted at edge N has out_valid=1 from cycle N+MEM_LAT+1.
- Store formatting, with sh = in_addr[1:0]:
  - SB: wmask = 8'h01<<sh; wdata = wdata[7:0]<<(8*sh).
  - SH: wmask = 8'h03<<sh; wdata = wdata[15:0]<<(8*sh).
  - SW: wmask = 8'h0F; wdata = in_wdata.
- Load formatting from mem_rdata:
  - LB/LBU: sign/zero-extend [7:0].
  - LH/LHU: sign/zero-extend [15:0].
  - LW: full word.
  - Other funct3: treated as LW.
- Boundary cases:
  - in_is_load and in_is_store both high: treated as load, store suppressed.
  - Reset asserted mid-ACCESS: mem_wen/mem_ren drop immediately (async); the op is discarded.
  - out_ready held high while in RESP: exactly one cycle of out_valid.
  - MEM_LAT=1: ACCESS lasts one cycle.

Optional Feature:
- Macro: YSYX_23060332_LSU_MISALIGN_CHECK_EN.
- When defined, a halfword access with addr[0]!=0, or a word access with addr[1:0]!=0:
  - skips ACCESS, with mem_ren/mem_wen never asserted;
  - goes from IDLE directly to RESP with out_err=1 and out_rdata=0.
- When undefined: out_err is constant 0 and misaligned ops proceed normally (unaligned read via the memory stage; store lanes shifted, with bits beyond lane 3 dropped).

Test Plan:
- Reset mid-store:
  - Assert rst during store ACCESS with MEM_LAT=3 -> mem_wen=0 immediately.
  - After release: in_ready=1, out_valid=0, no further write.
- SB lane shift: SB addr=0x80000003, wdata=0x000000AB, MEM_LAT=1.
  - One cycle: mem_wen=1, waddr=0x80000000, wmask=0x08, wdata=0xAB000000.
  - RESP: out_rdata=0.
- Sign vs zero extension:
  - LB addr=0x80000001 with mem_rdata=0x000000F0 -> out_rdata=0xFFFFFFF0.
  - LBU, same stimulus -> 0x000000F0.
  - LH with mem_rdata=0x00008001 -> 0xFFFF8001.
- Latency and stall: LW with MEM_LAT=4, accepted at edge 0.
  - mem_ren high for 4 cycles; out_valid from cycle 5.
  - Hold out_ready=0 for 3 cycles -> out_rdata stable, in_ready=0.
  - Second in_valid is not accepted until after out handshake.
- Non-memory op: in_is_load=in_is_store=0, rd=7 -> no mem_ren/mem_wen, out_valid next cycle, out_rd=7, out_rdata=0.
- Misalignment (macro on): LW addr=0x80000002 -> mem_ren never high, out_err=1, out_rdata=0.
  - Macro off, same stimulus -> normal read, out_err=0.
